// File: rtl/mesh_edge_feeder_pkg.sv
// Shared types and helpers for the mesh edge feeder: FSM state encoding
// and the flush length that lets the last slice reach the far corner PE.
package mesh_edge_feeder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      FLUSH,
      DRAIN
   } feeder_state_t;

   // Last beat needs 2N-1 cycles to cross the mesh diagonal, plus the multiply pipe.
   function automatic int flush_cycles(int n, int pipe_mul);
      return 2 * n - 1 + pipe_mul;
   endfunction

   function automatic int count_width(int max_value);
      return (max_value < 1) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/mesh_edge_feeder_if.sv
// Control, k-slice input and mesh edge bundle of the feeder. The master side
// is the tile sequencer / operand source, the slave side is the feeder.
interface mesh_edge_feeder_if #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int KW = 9
);
   logic           start;
   logic [KW-1:0]  k_len;
   logic           busy;
   logic           done;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] in_a;
   logic [N*W-1:0] in_b;
   logic [N*W-1:0] a_edge;
   logic [N-1:0]   a_edge_valid;
   logic [N*W-1:0] b_edge;
   logic [N-1:0]   b_edge_valid;
   logic           acc_clear_block;
   logic           drain;

   modport master (
      output start, k_len, in_valid, in_a, in_b,
      input  busy, done, in_ready, a_edge, a_edge_valid, b_edge, b_edge_valid,
             acc_clear_block, drain
   );

   modport slave (
      input  start, k_len, in_valid, in_a, in_b,
      output busy, done, in_ready, a_edge, a_edge_valid, b_edge, b_edge_valid,
             acc_clear_block, drain
   );
endinterface

// File: rtl/mesh_edge_feeder_skew_line.sv
// DEPTH-stage delay line for one {valid, data} operand lane; DEPTH=0 is a wire.
// Synchronous clear on !rst_n so a reset leaves no stale operands in flight.
module skew_line #(
   parameter int W     = 8,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   if (DEPTH == 0) begin : g_wire
      assign valid_o = valid_i;
      assign data_o  = data_i;
   end else begin : g_reg
      logic [DEPTH-1:0]   valid_q;
      logic [DEPTH*W-1:0] data_q;

      // Stage 0 sits in the low bits; the oldest entry leaves from the top.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
         end else begin
            valid_q <= (valid_q << 1) | DEPTH'(valid_i);
            data_q  <= (data_q << W) | (DEPTH*W)'(data_i);
         end
      end

      assign valid_o = valid_q[DEPTH-1];
      assign data_o  = data_q[DEPTH*W-1 -: W];
   end

endmodule

// File: rtl/mesh_edge_feeder.sv
// Transmit side of the PE-mesh operand protocol: sequences one C-tile
// (clear, stream, flush, drain) and drives skewed west/north edge operands.
module mesh_edge_feeder
   import mesh_edge_feeder_pkg::*;
#(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int KMAX     = 256,
   parameter int PIPE_MUL = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   mesh_edge_feeder_if.slave bus
);

   localparam int KW = count_width(KMAX);
   localparam int FL = flush_cycles(N, PIPE_MUL);
   localparam int FW = count_width(FL);

   feeder_state_t  state_q, state_d;
   logic [KW-1:0]  k_len_q, k_len_d;
   logic [KW-1:0]  beat_q, beat_d;
   logic [FW-1:0]  flush_q, flush_d;

   logic           busy_q;
   logic           done_q;
   logic           ready_q;
   logic           clear_q;
   logic           drain_q;

   logic           slot_valid_q;
   logic [N*W-1:0] slot_a_q;
   logic [N*W-1:0] slot_b_q;

   logic           accept;
   logic [N-1:0]   a_valid, b_valid;
   logic [N*W-1:0] a_data, b_data;

   assign accept = bus.in_valid & ready_q;

   always_comb begin
      state_d = state_q;
      k_len_d = k_len_q;
      beat_d  = beat_q;
      flush_d = flush_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               k_len_d = (bus.k_len > KW'(KMAX)) ? KW'(KMAX) : bus.k_len;
               beat_d  = '0;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            state_d = (k_len_q == '0) ? DRAIN : STREAM;
         end
         STREAM: begin
            if (accept) begin
               beat_d = beat_q + KW'(1);
               if (beat_q == k_len_q - KW'(1)) begin
                  flush_d = '0;
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (flush_q == FW'(FL - 1)) begin
               state_d = DRAIN;
            end else begin
               flush_d = flush_q + FW'(1);
            end
         end
         DRAIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         k_len_q      <= '0;
         beat_q       <= '0;
         flush_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ready_q      <= 1'b0;
         clear_q      <= 1'b0;
         drain_q      <= 1'b0;
         slot_valid_q <= 1'b0;
         slot_a_q     <= '0;
         slot_b_q     <= '0;
      end else begin
         state_q      <= state_d;
         k_len_q      <= k_len_d;
         beat_q       <= beat_d;
         flush_q      <= flush_d;
         busy_q       <= (state_d != IDLE);
         done_q       <= (state_d == DRAIN);
         ready_q      <= (state_d == STREAM);
         clear_q      <= (state_d == CLEAR);
         if (state_d == CLEAR) begin
            drain_q <= 1'b0;
         end else if (state_d == DRAIN) begin
            drain_q <= 1'b1;
         end
         slot_valid_q <= accept;
         slot_a_q     <= accept ? bus.in_a : '0;
         slot_b_q     <= accept ? bus.in_b : '0;
      end
   end

   // Lane gi waits gi extra cycles so a_k and b_k meet in PE(i,j) together.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      if (gi == 0) begin : g_direct
         assign a_valid[gi]        = slot_valid_q;
         assign b_valid[gi]        = slot_valid_q;
         assign a_data[gi*W +: W]  = slot_a_q[gi*W +: W];
         assign b_data[gi*W +: W]  = slot_b_q[gi*W +: W];
      end else begin : g_skew
         skew_line #(.W(W), .DEPTH(gi)) u_skew_a (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (slot_valid_q),
            .data_i  (slot_a_q[gi*W +: W]),
            .valid_o (a_valid[gi]),
            .data_o  (a_data[gi*W +: W])
         );
         skew_line #(.W(W), .DEPTH(gi)) u_skew_b (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (slot_valid_q),
            .data_i  (slot_b_q[gi*W +: W]),
            .valid_o (b_valid[gi]),
            .data_o  (b_data[gi*W +: W])
         );
      end
   end

   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.in_ready        = ready_q;
   assign bus.acc_clear_block = clear_q;
   assign bus.drain           = drain_q;
   assign bus.a_edge          = a_data;
   assign bus.a_edge_valid    = a_valid;
   assign bus.b_edge          = b_data;
   assign bus.b_edge_valid    = b_valid;

endmodule

// File: tb/tb_mesh_edge_feeder.sv
// Directed bench for mesh_edge_feeder: per-lane scoreboard of skewed edge
// operands plus a behavioural 4x4 PE mesh that accumulates what it receives.
module tb_mesh_edge_feeder;

   localparam int N    = 4;
   localparam int W    = 8;
   localparam int KMAX = 256;
   localparam int KW   = 9;
   localparam int FL   = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mesh_edge_feeder_if #(.N(N), .W(W), .KW(KW)) bus ();

   mesh_edge_feeder #(.N(N), .W(W), .KMAX(KMAX), .PIPE_MUL(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int           cyc;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } exp_t;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   exp_t sbq [N][$];

   int           acc [N][N];
   logic [W-1:0] ar  [N][N];
   logic [W-1:0] br  [N][N];
   logic         avr [N][N];
   logic         bvr [N][N];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one STREAM-cycle slot; an offered beat is expected on lane i at cyc+1+i.
   task automatic beat(logic v, logic [N*W-1:0] a, logic [N*W-1:0] b, string tag);
      bus.in_valid = v;
      bus.in_a     = a;
      bus.in_b     = b;
      chk({tag, "_ready"}, 32'(bus.in_ready), 1);
      if (v) begin
         for (int i = 0; i < N; i++)
            sbq[i].push_back('{cyc + 1 + i, a[i*W +: W], b[i*W +: W]});
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic start_tile(int k, string tag);
      bus.start = 1'b1;
      bus.k_len = KW'(k);
      tick();
      bus.start = 1'b0;
      chk({tag, "_clear"}, 32'(bus.acc_clear_block), 1);
      chk({tag, "_clear_drain"}, 32'(bus.drain), 0);
      chk({tag, "_clear_busy"}, 32'(bus.busy), 1);
      chk({tag, "_clear_ready"}, 32'(bus.in_ready), 0);
   endtask

   task automatic wait_done(int budget, string tag, output int n);
      n = 0;
      while (bus.done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_done_seen"}, 32'(bus.done === 1'b1), 1);
   endtask

   task automatic finish_tile(string tag);
      chk({tag, "_done"}, 32'(bus.done), 1);
      chk({tag, "_drain_rise"}, 32'(bus.drain), 1);
      chk({tag, "_drain_busy"}, 32'(bus.busy), 1);
      tick();
      chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
      chk({tag, "_idle_done"}, 32'(bus.done), 0);
      chk({tag, "_idle_drain"}, 32'(bus.drain), 1);
      chk({tag, "_idle_ready"}, 32'(bus.in_ready), 0);
   endtask

   // Edge monitor: valid lanes must match the scoreboard, invalid lanes carry zero.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         for (int i = 0; i < N; i++) begin
            chk("b_valid_eq_a", 32'(bus.b_edge_valid[i]), 32'(bus.a_edge_valid[i]));
            if (bus.a_edge_valid[i] === 1'b1) begin
               chk("lane_pending", 32'(sbq[i].size() > 0), 1);
               if (sbq[i].size() > 0) begin
                  e = sbq[i].pop_front();
                  chk("lane_cycle", cyc, e.cyc);
                  chk("lane_a", 32'(bus.a_edge[i*W +: W]), 32'(e.a));
                  chk("lane_b", 32'(bus.b_edge[i*W +: W]), 32'(e.b));
               end
            end else begin
               chk("idle_a", 32'(bus.a_edge[i*W +: W]), 0);
               chk("idle_b", 32'(bus.b_edge[i*W +: W]), 0);
            end
         end
      end
   end

   // Behavioural output-stationary mesh: a flows east, b flows south.
   always @(posedge clk) begin
      logic [W-1:0] ain, bin;
      logic         avin, bvin;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (j == 0) begin
               ain  = bus.a_edge[i*W +: W];
               avin = bus.a_edge_valid[i];
            end else begin
               ain  = ar[i][j-1];
               avin = avr[i][j-1];
            end
            if (i == 0) begin
               bin  = bus.b_edge[j*W +: W];
               bvin = bus.b_edge_valid[j];
            end else begin
               bin  = br[i-1][j];
               bvin = bvr[i-1][j];
            end
            if (!rst_n) begin
               ar[i][j]  <= '0;
               br[i][j]  <= '0;
               avr[i][j] <= 1'b0;
               bvr[i][j] <= 1'b0;
               acc[i][j] <= 0;
            end else begin
               ar[i][j]  <= ain;
               br[i][j]  <= bin;
               avr[i][j] <= avin;
               bvr[i][j] <= bvin;
               if (bus.acc_clear_block === 1'b1)
                  acc[i][j] <= 0;
               else if (avin === 1'b1 && bvin === 1'b1)
                  acc[i][j] <= acc[i][j] + (32'($signed(ain)) * 32'($signed(bin)));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.start    = 1'b0;
      bus.k_len    = '0;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_ready", 32'(bus.in_ready), 0);
      chk("rst_drain", 32'(bus.drain), 0);
      chk("rst_clear", 32'(bus.acc_clear_block), 0);
      chk("rst_a_valid", 32'(bus.a_edge_valid), 0);
      chk("rst_b_valid", 32'(bus.b_edge_valid), 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick();

      // 1: k_len=3, three back-to-back beats, flush length
      start_tile(3, "t1");
      tick();
      beat(1'b1, 32'h04030201, 32'h14131211, "t1b0");
      beat(1'b1, 32'h08070605, 32'h18171615, "t1b1");
      beat(1'b1, 32'h0c0b0a09, 32'h1c1b1a19, "t1b2");
      chk("t1_flush_ready", 32'(bus.in_ready), 0);
      chk("t1_flush_busy", 32'(bus.busy), 1);
      wait_done(20, "t1", n);
      chk("t1_flush_len", n, FL);
      finish_tile("t1");

      // 2: k_len=0 goes CLEAR -> DRAIN, done two cycles after start
      start_tile(0, "t2");
      tick();
      chk("t2_done_at_2", 32'(bus.done), 1);
      finish_tile("t2");

      // 3: bubble pattern 1,0,1 with k_len=2; start during FLUSH is ignored
      start_tile(2, "t3");
      tick();
      beat(1'b1, 32'h31323334, 32'h41424344, "t3b0");
      beat(1'b0, 32'hdeadbeef, 32'hcafef00d, "t3bub");
      beat(1'b1, 32'h35363738, 32'h45464748, "t3b1");
      chk("t3_flush_ready", 32'(bus.in_ready), 0);
      bus.start = 1'b1;
      bus.k_len = KW'(1);
      wait_done(20, "t3", n);
      chk("t3_flush_len", n, FL);
      bus.start = 1'b0;
      finish_tile("t3");
      tick();
      chk("t3_start_not_queued", 32'(bus.busy), 0);

      // 4: start on the done cycle is ignored; one cycle later it is taken
      start_tile(1, "t4");
      tick();
      beat(1'b1, 32'h0a0b0c0d, 32'h1a1b1c1d, "t4b0");
      wait_done(20, "t4", n);
      chk("t4_flush_len", n, FL);
      bus.start = 1'b1;
      bus.k_len = KW'(1);
      tick();
      chk("t4_ignored_busy", 32'(bus.busy), 0);
      chk("t4_ignored_clear", 32'(bus.acc_clear_block), 0);
      chk("t4_idle_drain", 32'(bus.drain), 1);
      tick();
      bus.start = 1'b0;
      chk("t4_b2b_clear", 32'(bus.acc_clear_block), 1);
      chk("t4_b2b_drain_fall", 32'(bus.drain), 0);
      tick();
      beat(1'b1, 32'h2a2b2c2d, 32'h3a3b3c3d, "t4b1");
      wait_done(20, "t4b", n);
      finish_tile("t4b");

      // 5: reset after one of four beats flushes skew stages
      start_tile(4, "t5");
      tick();
      beat(1'b1, 32'h55667788, 32'h99aabbcc, "t5b0");
      rst_n = 1'b0;
      for (int i = 1; i < N; i++) sbq[i].delete();
      tick();
      chk("t5_rst_a_valid", 32'(bus.a_edge_valid), 0);
      chk("t5_rst_b_valid", 32'(bus.b_edge_valid), 0);
      chk("t5_rst_drain", 32'(bus.drain), 0);
      chk("t5_rst_busy", 32'(bus.busy), 0);
      chk("t5_rst_ready", 32'(bus.in_ready), 0);
      rst_n = 1'b1;
      tick();
      start_tile(2, "t5n");
      tick();
      beat(1'b1, 32'h01020304, 32'h05060708, "t5nb0");
      beat(1'b1, 32'h090a0b0c, 32'h0d0e0f10, "t5nb1");
      wait_done(20, "t5n", n);
      chk("t5n_flush_len", n, FL);
      finish_tile("t5n");

      // 6a: end-to-end, all-ones operands, K=5
      start_tile(5, "t6a");
      tick();
      for (int k = 0; k < 5; k++) beat(1'b1, {N{8'h01}}, {N{8'h01}}, "t6a");
      wait_done(20, "t6a", n);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            chk($sformatf("t6a_acc_%0d_%0d", i, j), acc[i][j], 5);
      finish_tile("t6a");

      // 6b: -128 x -128 over K=256, requested as k_len=300 which clamps to KMAX
      start_tile(300, "t6b");
      tick();
      for (int k = 0; k < KMAX; k++) beat(1'b1, {N{8'h80}}, {N{8'h80}}, "t6b");
      chk("t6b_clamped_ready", 32'(bus.in_ready), 0);
      wait_done(20, "t6b", n);
      chk("t6b_flush_len", n, FL);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            chk($sformatf("t6b_acc_%0d_%0d", i, j), acc[i][j], 4194304);
      finish_tile("t6b");

      repeat (2 * N) tick();
      for (int i = 0; i < N; i++)
         chk($sformatf("sb_empty_%0d", i), sbq[i].size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
